// File: rtl/temp_bcd_formatter_pkg.sv
// Shared definitions for the temperature-to-BCD formatter.
// Contents: Q8.8 field widths, the blank digit code, and the control FSM state type.
package temp_bcd_formatter_pkg;

  localparam int unsigned INT_W   = 8;
  localparam int unsigned FRAC_W  = 8;
  localparam int unsigned VALUE_W = INT_W + FRAC_W;
  localparam int unsigned DIGIT_W = 4;
  // Three BCD nibbles: hundreds, tens and ones.
  localparam int unsigned BCD_W   = 3 * DIGIT_W;

  // Any digit code above 9 is shown as blank by the segment decoder.
  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StFinish
  } state_e;

endpackage

// File: rtl/temp_bcd_formatter_if.sv
// Handshake and result bundle between the display control FSM and the formatter.
//   master: drives start/value, receives busy/done and the digit results.
//   slave : the formatter side.
//   start  request a conversion (taken only while busy=0)
//   value  signed Q8.8 temperature, sampled on the accepting edge
//   busy   conversion in progress
//   done   one-cycle pulse when the digit outputs update
//   neg, tens, ones, tenths, ovf  registered result of the last conversion
interface temp_bcd_formatter_if;
  import temp_bcd_formatter_pkg::*;

  logic               start;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               done;
  logic               neg;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic [DIGIT_W-1:0] tenths;
  logic               ovf;

  modport master (
    output start, value,
    input  busy, done, neg, tens, ones, tenths, ovf
  );

  modport slave (
    input  start, value,
    output busy, done, neg, tens, ones, tenths, ovf
  );

endinterface

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
//   din   nibble before correction
//   dout  corrected nibble
module bcd_add3_nibble
  import temp_bcd_formatter_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/temp_bcd_formatter.sv
// Converts a signed Q8.8 temperature into sign, tens, ones and tenths BCD digits for
// the 7-segment display path. The integer magnitude goes through an 8-iteration
// double-dabble engine; the tenths digit is floor(frac*10/256) by shift-add.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  slave side of temp_bcd_formatter_if (start/value in, busy/done/digits out)
module temp_bcd_formatter
  import temp_bcd_formatter_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] OVF_FILL = BCD_BLANK,
  parameter int unsigned        MAX_INT  = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  temp_bcd_formatter_if.slave  bus
);

  state_e               state_q;
  logic [VALUE_W-1:0]   value_q;
  logic [INT_W-1:0]     bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [2:0]           cnt_q;
  logic [DIGIT_W-1:0]   tenths_tmp_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 neg_q;
  logic [DIGIT_W-1:0]   tens_q;
  logic [DIGIT_W-1:0]   ones_q;
  logic [DIGIT_W-1:0]   tenths_q;
  logic                 ovf_q;

  logic [VALUE_W-1:0]   mag;
  logic [11:0]          frac_x10;
  logic [DIGIT_W-1:0]   tenths_calc;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_shift;
  logic [INT_W-1:0]     bin_shift;
  logic [7:0]           two_digit;
  logic                 ovf_calc;

  for (genvar i = 0; i < 3; i++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .din  (bcd_q[i*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    // 16-bit wrap: 0x8000 negates to itself, giving integer byte 128 (flagged ovf).
    mag         = value_q[VALUE_W-1] ? (~value_q + 16'd1) : value_q;
    frac_x10    = ({4'd0, mag[FRAC_W-1:0]} << 3) + ({4'd0, mag[FRAC_W-1:0]} << 1);
    tenths_calc = 4'(frac_x10 >> 8);
    {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;
    two_digit   = 8'(bcd_q[7:4]) * 8'd10 + 8'(bcd_q[3:0]);
    ovf_calc    = (bcd_q[11:8] != 4'd0) || (32'(two_digit) > MAX_INT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      value_q      <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      tenths_tmp_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      neg_q        <= 1'b0;
      tens_q       <= '0;
      ones_q       <= '0;
      tenths_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            value_q <= bus.value;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          bin_q        <= mag[VALUE_W-1:FRAC_W];
          bcd_q        <= '0;
          cnt_q        <= 3'd7;
          tenths_tmp_q <= tenths_calc;
          state_q      <= StShift;
        end
        StShift: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          neg_q  <= value_q[VALUE_W-1];
          ovf_q  <= ovf_calc;
          if (ovf_calc) begin
            tens_q   <= OVF_FILL;
            ones_q   <= OVF_FILL;
            tenths_q <= OVF_FILL;
          end else begin
            tens_q   <= bcd_q[7:4];
            ones_q   <= bcd_q[3:0];
            tenths_q <= tenths_tmp_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.neg    = neg_q;
  assign bus.tens   = tens_q;
  assign bus.ones   = ones_q;
  assign bus.tenths = tenths_q;
  assign bus.ovf    = ovf_q;

endmodule
